// File: rtl/phase_frame_loader.sv
// Host byte-stream parser feeding a shadow phase/calib/enable bank that commits
// atomically to the active PWM bank on the last count of a PWM period.
module phase_frame_loader #(
    parameter int unsigned NUM_CHANNELS   = 128,
    parameter int unsigned CLK_CNT_W      = 8,
    parameter int unsigned CLK_CNT_MAX    = 255,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [7:0]                        rx_data,
    input  logic                              rx_valid,
    output logic                              rx_ready,
    input  logic [CLK_CNT_W-1:0]              pwm_cnt,
    input  logic                              err_clr,
    output logic [CLK_CNT_W*NUM_CHANNELS-1:0] phases_out,
    output logic [NUM_CHANNELS-1:0]           en_out,
    output logic                              commit_pending,
    output logic                              commit_done,
    output logic [15:0]                       frame_cnt,
    output logic [2:0]                        err_flags
);

    localparam int unsigned M     = CLK_CNT_MAX + 1;
    localparam int unsigned IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [TO_W-1:0]      TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CLK_CNT_W:0]   M_W     = (CLK_CNT_W + 1)'(M);
    localparam logic [CLK_CNT_W-1:0] CNT_MAX = CLK_CNT_W'(CLK_CNT_MAX);

    localparam logic [1:0] S_HDR    = 2'd0;
    localparam logic [1:0] S_IDX_HI = 2'd1;
    localparam logic [1:0] S_IDX_LO = 2'd2;
    localparam logic [1:0] S_VAL    = 2'd3;

    localparam logic [1:0] OP_PHASE  = 2'b00;
    localparam logic [1:0] OP_CALIB  = 2'b01;
    localparam logic [1:0] OP_ENABLE = 2'b10;
    localparam logic [1:0] OP_COMMIT = 2'b11;

    logic [1:0]            state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [7:0]            idx_hi_q, idx_hi_d;
    logic [7:0]            idx_lo_q, idx_lo_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;

    logic [CLK_CNT_W-1:0]  sh_phase_q [NUM_CHANNELS];
    logic [CLK_CNT_W-1:0]  sh_phase_d [NUM_CHANNELS];
    logic [CLK_CNT_W-1:0]  sh_calib_q [NUM_CHANNELS];
    logic [CLK_CNT_W-1:0]  sh_calib_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] sh_en_q, sh_en_d;

    logic [CLK_CNT_W-1:0]  act_phase_q [NUM_CHANNELS];
    logic [CLK_CNT_W-1:0]  act_phase_d [NUM_CHANNELS];
    logic [CLK_CNT_W-1:0]  phase_next  [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] act_en_q, act_en_d;

    logic                  commit_pending_q, commit_pending_d;
    logic                  commit_done_q, commit_done_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic [2:0]            err_q, err_d;

    logic                  accept;
    logic                  swap;
    logic [15:0]           idx;
    logic                  idx_ok;
    logic [IDX_W-1:0]      widx;
    logic [CLK_CNT_W-1:0]  val_mod;
    logic [CLK_CNT_W:0]    sum;

    assign rx_ready = !commit_pending_q;
    assign accept   = rx_valid && rx_ready;
    assign swap     = commit_pending_q && (pwm_cnt == CNT_MAX);
    assign idx      = {idx_hi_q, idx_lo_q};
    assign idx_ok   = (32'(idx) < NUM_CHANNELS);
    assign widx     = idx[IDX_W-1:0];
    assign val_mod  = CLK_CNT_W'(32'(rx_data) % M);

    // Calibrated phase for every channel, reduced mod M with a single conditional subtract.
    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            sum = {1'b0, sh_phase_q[i]} + {1'b0, sh_calib_q[i]};
            if (sum >= M_W) begin
                sum = sum - M_W;
            end
            phase_next[i] = sum[CLK_CNT_W-1:0];
        end
    end

    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        idx_hi_d         = idx_hi_q;
        idx_lo_d         = idx_lo_q;
        to_cnt_d         = to_cnt_q;
        sh_phase_d       = sh_phase_q;
        sh_calib_d       = sh_calib_q;
        sh_en_d          = sh_en_q;
        act_phase_d      = act_phase_q;
        act_en_d         = act_en_q;
        commit_pending_d = commit_pending_q;
        commit_done_d    = swap;
        frame_cnt_d      = frame_cnt_q;
        err_d            = err_clr ? 3'b000 : err_q;

        case (state_q)
            S_HDR: begin
                to_cnt_d = '0;
                if (accept) begin
                    if (rx_data[5:0] != 6'd0) begin
                        err_d[0] = 1'b1;
                    end else begin
                        op_d    = rx_data[7:6];
                        state_d = S_IDX_HI;
                    end
                end
            end
            S_IDX_HI: begin
                if (accept) begin
                    idx_hi_d = rx_data;
                    to_cnt_d = '0;
                    state_d  = S_IDX_LO;
                end
            end
            S_IDX_LO: begin
                if (accept) begin
                    idx_lo_d = rx_data;
                    to_cnt_d = '0;
                    state_d  = S_VAL;
                end
            end
            S_VAL: begin
                if (accept) begin
                    to_cnt_d = '0;
                    state_d  = S_HDR;
                    if (op_q == OP_COMMIT) begin
                        commit_pending_d = 1'b1;
                    end else if (!idx_ok) begin
                        err_d[1] = 1'b1;
                    end else begin
                        case (op_q)
                            OP_PHASE:  sh_phase_d[widx] = val_mod;
                            OP_CALIB:  sh_calib_d[widx] = val_mod;
                            OP_ENABLE: sh_en_d[widx]    = rx_data[0];
                            default:   ;
                        endcase
                    end
                end
            end
            default: state_d = S_HDR;
        endcase

        // Idle inside a partial packet: abandon it after TIMEOUT_CYCLES without a byte.
        if (state_q != S_HDR && !accept) begin
            if (to_cnt_q == TO_LAST) begin
                state_d  = S_HDR;
                to_cnt_d = '0;
                err_d[2] = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end

        // Shadow writes cannot coincide with a swap: rx_ready is low while pending.
        if (swap) begin
            act_phase_d      = phase_next;
            act_en_d         = sh_en_q;
            commit_pending_d = 1'b0;
            frame_cnt_d      = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_HDR;
            op_q             <= '0;
            idx_hi_q         <= '0;
            idx_lo_q         <= '0;
            to_cnt_q         <= '0;
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                sh_phase_q[i]  <= '0;
                sh_calib_q[i]  <= '0;
                act_phase_q[i] <= '0;
            end
            sh_en_q          <= '0;
            act_en_q         <= '0;
            commit_pending_q <= 1'b0;
            commit_done_q    <= 1'b0;
            frame_cnt_q      <= '0;
            err_q            <= '0;
        end else begin
            state_q          <= state_d;
            op_q             <= op_d;
            idx_hi_q         <= idx_hi_d;
            idx_lo_q         <= idx_lo_d;
            to_cnt_q         <= to_cnt_d;
            sh_phase_q       <= sh_phase_d;
            sh_calib_q       <= sh_calib_d;
            act_phase_q      <= act_phase_d;
            sh_en_q          <= sh_en_d;
            act_en_q         <= act_en_d;
            commit_pending_q <= commit_pending_d;
            commit_done_q    <= commit_done_d;
            frame_cnt_q      <= frame_cnt_d;
            err_q            <= err_d;
        end
    end

    always_comb begin
        phases_out = '0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            phases_out[i*CLK_CNT_W +: CLK_CNT_W] = act_phase_q[i];
        end
    end

    assign en_out         = act_en_q;
    assign commit_pending = commit_pending_q;
    assign commit_done    = commit_done_q;
    assign frame_cnt      = frame_cnt_q;
    assign err_flags      = err_q;

endmodule

// File: tb/tb_phase_frame_loader.sv
// Scoreboard bench for phase_frame_loader: a host-side model predicts each committed
// frame and its swap cycle; a monitor checks them on every commit_done pulse.
module tb_phase_frame_loader;

    localparam int NCH = 8;
    localparam int W   = 8;
    localparam int MAX = 199;
    localparam int M   = MAX + 1;
    localparam int TO  = 32;

    typedef struct {
        logic [NCH*W-1:0] ph;
        logic [NCH-1:0]   en;
        logic [15:0]      fr;
        longint           dc;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic [W-1:0]     pwm_cnt = '0;
    logic             err_clr;
    logic [NCH*W-1:0] phases_out;
    logic [NCH-1:0]   en_out;
    logic             commit_pending;
    logic             commit_done;
    logic [15:0]      frame_cnt;
    logic [2:0]       err_flags;

    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;
    longint acc_cyc;
    int     acc_pwm;

    exp_t   sb[$];
    exp_t   mon_e;
    int     mph  [NCH];
    int     mcal [NCH];
    logic [NCH-1:0] men;
    logic [15:0]    mframe;

    phase_frame_loader #(
        .NUM_CHANNELS   (NCH),
        .CLK_CNT_W      (W),
        .CLK_CNT_MAX    (MAX),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .pwm_cnt        (pwm_cnt),
        .err_clr        (err_clr),
        .phases_out     (phases_out),
        .en_out         (en_out),
        .commit_pending (commit_pending),
        .commit_done    (commit_done),
        .frame_cnt      (frame_cnt),
        .err_flags      (err_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        pwm_cnt <= (pwm_cnt == W'(MAX)) ? '0 : pwm_cnt + 1'b1;
        cyc     <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && commit_done) begin
            if (sb.size() == 0) begin
                chk("unexp_done", 64'(commit_done), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("phases", phases_out, mon_e.ph);
                chk("en", 64'(en_out), 64'(mon_e.en));
                chk("frame", 64'(frame_cnt), 64'(mon_e.fr));
                chk("done_cyc", cyc, mon_e.dc);
                chk("done_pwm", 64'(pwm_cnt), 64'd0);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 4 * M) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) chk("rdy_wait", 64'(rx_ready), 64'd1);
        acc_cyc = cyc;
        acc_pwm = int'(pwm_cnt);
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            mph[i]  = 0;
            mcal[i] = 0;
        end
        men    = '0;
        mframe = '0;
        sb.delete();
    endtask

    // vat >= 0 aligns the packet so the VAL byte is accepted while pwm_cnt == vat.
    task automatic send_pkt(input logic [1:0] op, input logic [15:0] idx,
                            input logic [7:0] val, input int vat);
        exp_t e;
        int   n = 0;
        int   s;
        int   delta;
        if (vat >= 0) begin
            while (int'(pwm_cnt) != (vat + M - 4) % M && n < 2 * M) begin
                @(negedge clk);
                n++;
            end
        end
        send_byte({op, 6'b000000});
        send_byte(idx[15:8]);
        send_byte(idx[7:0]);
        send_byte(val);
        if (op == 2'b11) begin
            mframe = mframe + 16'd1;
            for (int i = 0; i < NCH; i++) begin
                s = (mph[i] + mcal[i]) % M;
                e.ph[i*W +: W] = W'(s);
            end
            e.en  = men;
            e.fr  = mframe;
            delta = (acc_pwm == MAX) ? M : (MAX - acc_pwm);
            e.dc  = acc_cyc + longint'(delta) + 1;
            sb.push_back(e);
        end else if (int'(idx) < NCH) begin
            case (op)
                2'b00:   mph[idx]  = int'(val) % M;
                2'b01:   mcal[idx] = int'(val) % M;
                default: men[idx]  = val[0];
            endcase
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 3 * M) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        rx_data  = '0;
        rx_valid = 1'b0;
        err_clr  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(rx_ready), 64'd1);
        chk("rst_phases", phases_out, 64'd0);
        chk("rst_en", 64'(en_out), 64'd0);
        chk("rst_pend", 64'(commit_pending), 64'd0);
        chk("rst_frame", 64'(frame_cnt), 64'd0);
        chk("rst_err", 64'(err_flags), 64'd0);
        rst_n = 1'b1;

        // Basic write and commit
        send_pkt(2'b00, 16'd5, 8'h40, -1);
        send_pkt(2'b01, 16'd5, 8'h10, -1);
        send_pkt(2'b10, 16'd5, 8'h01, -1);
        send_pkt(2'b11, 16'd0, 8'h00, -1);
        drain();
        chk("ch5_phase", 64'(phases_out[5*W +: W]), 64'h50);

        // Modular reduction of the calibrated sum and of a raw VAL
        send_pkt(2'b00, 16'd2, 8'd150, -1);
        send_pkt(2'b01, 16'd2, 8'd100, -1);
        send_pkt(2'b00, 16'd3, 8'd250, -1);
        send_pkt(2'b11, 16'd0, 8'h00, -1);
        drain();
        chk("ch2_wrap", 64'(phases_out[2*W +: W]), 64'd50);
        chk("ch3_wrap", 64'(phases_out[3*W +: W]), 64'd50);

        // Freeze: bytes after COMMIT wait for the swap and land in shadow only
        send_pkt(2'b11, 16'd0, 8'h00, 20);
        chk("frz_ready", 64'(rx_ready), 64'd0);
        chk("frz_pend", 64'(commit_pending), 64'd1);
        send_pkt(2'b00, 16'd1, 8'd7, -1);
        drain();
        chk("frz_ready_back", 64'(rx_ready), 64'd1);
        chk("frz_ch1_old", 64'(phases_out[1*W +: W]), 64'd0);
        send_pkt(2'b11, 16'd0, 8'h00, -1);
        drain();

        // Bad header, resync, out-of-range index, clear
        send_byte(8'h05);
        chk("err_hdr", 64'(err_flags), 64'b001);
        send_pkt(2'b00, 16'd0, 8'd9, -1);
        send_pkt(2'b00, 16'(NCH), 8'd3, -1);
        chk("err_range", 64'(err_flags), 64'b011);
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        chk("err_clr", 64'(err_flags), 64'b000);
        send_pkt(2'b11, 16'd0, 8'h00, -1);
        drain();

        // Timeout inside a partial packet
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (TO - 1) @(posedge clk);
        #1 chk("to_early", 64'(err_flags), 64'b000);
        @(posedge clk);
        #1 chk("to_set", 64'(err_flags), 64'b100);
        send_pkt(2'b00, 16'd4, 8'd33, -1);
        send_pkt(2'b11, 16'd0, 8'h00, -1);
        drain();

        // COMMIT accepted on the last PWM count waits a full period
        send_pkt(2'b10, 16'd7, 8'h01, -1);
        send_pkt(2'b11, 16'd0, 8'h00, MAX);
        drain();

        // Reset while a commit is pending
        send_pkt(2'b00, 16'd6, 8'd77, -1);
        send_pkt(2'b11, 16'd0, 8'h00, 20);
        chk("pre_rst_pend", 64'(commit_pending), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_phases", phases_out, 64'd0);
        chk("mid_rst_en", 64'(en_out), 64'd0);
        chk("mid_rst_pend", 64'(commit_pending), 64'd0);
        chk("mid_rst_frame", 64'(frame_cnt), 64'd0);
        chk("mid_rst_ready", 64'(rx_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (M + 20) @(negedge clk);
        chk("post_rst_frame", 64'(frame_cnt), 64'd0);
        chk("post_rst_phases", phases_out, 64'd0);
        chk("post_rst_pend", 64'(commit_pending), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/phase_frame_loader.md
# phase_frame_loader

Byte-stream command parser and double-buffered phase store for the transducer array, replacing the per-channel phase parser instances. It consumes host bytes from the proto245 RX FIFO and writes phase, calibration and enable values into a shadow bank. The shadow bank commits atomically to the active bank on a PWM period boundary. The active bank drives the per-channel PWM generators with calibrated phases.

## Interface
Parameters:
- NUM_CHANNELS, 128, number of transducer channels (1..65535)
- CLK_CNT_W, 8, phase / PWM counter width
- CLK_CNT_MAX, 255, last PWM count value; period is M = CLK_CNT_MAX+1, with M ≤ 2^CLK_CNT_W
- TIMEOUT_CYCLES, 1024, idle clocks allowed inside a partial packet

Ports:
- clk  in  1  single clock (PWM/system clock)
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  RX byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  block accepts byte; transfer when rx_valid && rx_ready
- pwm_cnt  in  CLK_CNT_W  shared PWM counter
- err_clr  in  1  clears err_flags
- phases_out  out  CLK_CNT_W×NUM_CHANNELS  active calibrated phases
- en_out  out  NUM_CHANNELS  active channel enables
- commit_pending  out  1  commit requested, swap not yet done
- commit_done  out  1  one-cycle pulse on swap
- frame_cnt  out  16  number of commits, wraps
- err_flags  out  3  sticky: [0] bad header, [1] channel out of range, [2] timeout

## Operation
- Packet format: 4 bytes: HDR, IDX_HI, IDX_LO, VAL.
  - HDR[7:6] is the opcode: 00 PHASE, 01 CALIB, 10 ENABLE, 11 COMMIT.
  - HDR[5:0] must be 0.
- Parser FSM states: S_HDR → S_IDX_HI → S_IDX_LO → S_VAL → S_HDR. The FSM advances only on an accepted byte.
- Bad header: HDR[5:0] ≠ 0 sets err_flags[0]. The FSM stays in S_HDR and the byte is dropped. Resync happens on the next byte.
- On VAL accept, idx = {IDX_HI, IDX_LO}:
  - PHASE: shadow_phase[idx] ← VAL mod M.
  - CALIB: shadow_calib[idx] ← VAL mod M.
  - ENABLE: shadow_en[idx] ← VAL[0].
  - COMMIT: idx and VAL are ignored; sets commit_pending.
- idx ≥ NUM_CHANNELS on PHASE, CALIB or ENABLE: no write, and err_flags[1] is set.
- Timeout: in S_IDX_HI, S_IDX_LO or S_VAL, TIMEOUT_CYCLES consecutive cycles without an accepted byte cause the FSM to return to S_HDR and set err_flags[2]. Shadow is untouched.
- rx_ready = !commit_pending. The shadow bank is frozen from commit request until swap.
- Swap: occurs in the cycle where commit_pending && pwm_cnt == CLK_CNT_MAX. On that clock edge:
  - phases_out[i] ← (shadow_phase[i] + shadow_calib[i]) mod M for all i. Use a CLK_CNT_W+1-bit sum; subtract M if the sum is ≥ M.
  - en_out ← shadow_en.
  - commit_pending ← 0.
  - frame_cnt += 1.
  - commit_done = 1 for that following cycle.
- Shadow contents persist across commits; only written entries change.
- err_flags are sticky and cleared by err_clr. Priority: a set in the same cycle as err_clr wins.

## Timing
- Reset (async assert, sync deassert handled externally). All of these reset to 0: FSM S_HDR, shadow banks, phases_out, en_out, commit_pending, commit_done, frame_cnt, err_flags, timeout counter. rx_ready resets to 1.
- Shadow write is visible one clock after VAL accept.
- COMMIT VAL accepted at edge t sets commit_pending at t. The swap uses the first pwm_cnt == CLK_CNT_MAX at or after cycle t+1.
  - If pwm_cnt == CLK_CNT_MAX in the accept cycle itself, the swap waits one full period (M cycles).
- New phases_out and en_out are valid in the cycle with pwm_cnt == 0. The PWMs never see a mixed frame.
- rx_ready drops the cycle after COMMIT acceptance and returns to 1 the cycle after the swap.
- Timeout counter resets on every accepted byte and on entry to S_HDR.
- Reset mid-packet or mid-pending discards the partial packet and the pending commit; outputs go to 0 immediately.

## Test plan
- Phase write and commit:
  - Stimulus: PHASE ch 5 = 0x40, CALIB ch 5 = 0x10, ENABLE ch 5 = 1, COMMIT.
  - Response: phases_out[5] = 0x50 and en_out[5] = 1, first valid at pwm_cnt = 0; commit_done pulses once; frame_cnt = 1.
- Modular wrap:
  - Stimulus: CLK_CNT_MAX = 199 (M = 200), phase 150, calib 100.
  - Response: phases_out = 50.
  - Stimulus: VAL = 250 written as a phase.
  - Response: stored as 50.
- Freeze:
  - Stimulus: COMMIT followed by back-to-back valid bytes.
  - Response: rx_ready = 0 until the swap; the following PHASE write lands in shadow only and reaches the outputs only at the next commit.
- Errors:
  - Stimulus: HDR = 0x05.
  - Response: err_flags[0] set; the next valid packet is parsed correctly.
  - Stimulus: idx = NUM_CHANNELS.
  - Response: err_flags[1] set, no write.
  - Stimulus: err_clr.
  - Response: flags = 0.
- Timeout:
  - Stimulus: send HDR, IDX_HI, then idle TIMEOUT_CYCLES.
  - Response: err_flags[2] set, FSM back in S_HDR; the next 4-byte packet takes effect.
- Boundary and reset:
  - Stimulus: COMMIT accepted when pwm_cnt = CLK_CNT_MAX.
  - Response: swap occurs M cycles later.
  - Stimulus: rst_n asserted while commit_pending.
  - Response: all outputs = 0; no commit after release.
